// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store access controller between the execute stage and a handshaked data memory
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic        Dmem_rd_en,
    input  logic        Dmem_wr_en,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  MemRead,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic        req, illegal, accept, timeout;
    logic        is_byte, is_half, is_word;
    logic        flush_q, bus_q, load_q;
    logic [1:0]  off_q;
    logic [2:0]  type_q;
    logic [4:0]  cnt;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt, cap_q, ext;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Decode the incoming request: access width, legality, lane enables and replicated store data
    always_comb begin
        req       = ex_valid & ~flush & (Dmem_rd_en | Dmem_wr_en);
        is_byte   = Dmem_rd_en ? (MemRead == 3'b001 || MemRead == 3'b011) : (MemWrite == 2'b01);
        is_half   = Dmem_rd_en ? (MemRead == 3'b010 || MemRead == 3'b100) : (MemWrite == 2'b10);
        is_word   = Dmem_rd_en ? (MemRead == 3'b000) : (MemWrite == 2'b11);
        illegal   = (Dmem_rd_en & Dmem_wr_en) | ~(is_byte | is_half | is_word)
                  | (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
        accept    = (state == IDLE) & req & ~illegal;
        timeout   = cnt == 5'(TIMEOUT - 1);
        be_nxt    = is_byte ? 4'b0001 << addr[1:0] : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_nxt = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept only from IDLE, ack beats timeout in BUSY, DONE/ERR last one cycle
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = req ? (illegal ? ERR : BUSY) : IDLE;
            BUSY:    state_nxt = mem_ack ? DONE : (timeout ? ERR : BUSY);
            default: state_nxt = IDLE;
        endcase
    end

    // Bus request registers: loaded on acceptance, held through BUSY, request dropped on ack or timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= Dmem_wr_en;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
        end else if (state == BUSY && (mem_ack || timeout)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Transaction bookkeeping: wait counter, read-word capture, flush latch and error cause
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            cap_q   <= '0;
            flush_q <= 1'b0;
            bus_q   <= 1'b0;
            load_q  <= 1'b0;
            type_q  <= '0;
            off_q   <= '0;
        end else begin
            bus_q   <= (state == BUSY) && !mem_ack && timeout;
            flush_q <= (state_nxt == IDLE) ? 1'b0 : flush_q | ((state == BUSY) & flush);
            if (accept) begin
                cnt    <= '0;
                load_q <= Dmem_rd_en;
                type_q <= MemRead;
                off_q  <= addr[1:0];
            end else if (state == BUSY) begin
                if (mem_ack) cap_q <= mem_rdata;
                else         cnt   <= cnt + 5'd1;
            end
        end
    end

    // Pick the addressed byte/half out of the captured word and extend it
    always_comb begin
        sel_b = cap_q[{off_q, 3'b000} +: 8];
        sel_h = off_q[1] ? cap_q[31:16] : cap_q[15:0];
        case (type_q)
            3'b001:  ext = {{24{sel_b[7]}}, sel_b};
            3'b011:  ext = {24'b0, sel_b};
            3'b010:  ext = {{16{sel_h[15]}}, sel_h};
            3'b100:  ext = {16'b0, sel_h};
            default: ext = cap_q;
        endcase
    end

    // Pipeline-facing outputs derived from state and latched transaction info
    always_comb begin
        stall       = ((state == IDLE) & req) | (state == BUSY);
        rdata_valid = (state == DONE) & load_q & ~flush_q;
        rdata       = ((state == DONE) & load_q) ? ext : 32'b0;
        access_err  = (state == ERR) & ~bus_q;
        bus_err     = (state == ERR) & bus_q;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk, rst_n, ex_valid, flush, Dmem_rd_en, Dmem_wr_en;
    logic [1:0]  MemWrite;
    logic [2:0]  MemRead;
    logic [31:0] addr, wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic [3:0]  mem_be;
    logic        stall, rdata_valid, access_err, bus_err;

    typedef struct {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wd;} bus_t;
    typedef struct {logic [2:0] flags; logic [31:0] data;} resp_t;

    bus_t  exp_bus[$];
    resp_t exp_resp[$];
    bus_t  cur;
    int    checks = 0;
    int    failures = 0;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush),
        .Dmem_rd_en(Dmem_rd_en), .Dmem_wr_en(Dmem_wr_en), .MemWrite(MemWrite), .MemRead(MemRead),
        .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
        .access_err(access_err), .bus_err(bus_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT starts a bus request or presents a response
    initial begin
        logic prev_req;
        resp_t r;
        prev_req = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && !prev_req) begin
                if (exp_bus.size() == 0) check("bus_unexpected", {31'b0, mem_req}, 32'd0);
                else begin
                    cur = exp_bus.pop_front();
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_be", {28'b0, mem_be}, {28'b0, cur.be});
                    check("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
                    check("mem_wdata", mem_wdata, cur.wd);
                end
            end else if (mem_req) begin
                check("hold_addr", mem_addr, cur.addr);
                check("hold_be", {28'b0, mem_be}, {28'b0, cur.be});
                check("hold_wdata", mem_wdata, cur.wd);
            end
            prev_req = mem_req;
            if (rdata_valid || access_err || bus_err) begin
                if (exp_resp.size() == 0)
                    check("resp_unexpected", {29'b0, rdata_valid, access_err, bus_err}, 32'd0);
                else begin
                    r = exp_resp.pop_front();
                    check("resp_flags", {29'b0, rdata_valid, access_err, bus_err}, {29'b0, r.flags});
                    if (r.flags[2]) check("rdata", rdata, r.data);
                end
            end
        end
    end

    // One transaction; d = BUSY cycle carrying ack (0: never), f = BUSY cycle carrying flush (0: none)
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] mr, input logic [1:0] mw,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                           input int d, input int f, input bit fl_idle);
        int n;
        bit legal;
        logic [31:0] ewd, v, mask;
        logic [3:0] be;
        bus_t b;
        resp_t r;
        n = rd ? (mr == 0 ? 4 : (mr == 1 || mr == 3) ? 1 : (mr == 2 || mr == 4) ? 2 : 0)
               : (mw == 1 ? 1 : mw == 2 ? 2 : mw == 3 ? 4 : 0);
        legal = (rd != wr) && n != 0 && (a % n == 0);
        @(negedge clk);
        ex_valid = 1; flush = fl_idle; Dmem_rd_en = rd; Dmem_wr_en = wr;
        MemRead = mr; MemWrite = mw; addr = a; wdata = wd; mem_ack = 0;
        if (!fl_idle && (rd || wr)) begin
            if (legal) begin
                be = 4'(((1 << n) - 1) << (a % 4));
                for (int i = 0; i < 4; i++) ewd[8*i +: 8] = 8'(wd >> (8 * (i % n)));
                b.addr = a & ~32'd3; b.be = be; b.we = wr; b.wd = ewd;
                exp_bus.push_back(b);
                if (d == 0) begin
                    r.flags = 3'b001; r.data = 0;
                    exp_resp.push_back(r);
                end else if (rd && (f == 0 || f > d)) begin
                    v = rw >> (8 * (a % 4));
                    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 1;
                    v = v & mask;
                    if ((mr == 1 || mr == 2) && v[8*n-1]) v = v | ~mask;
                    r.flags = 3'b100; r.data = v;
                    exp_resp.push_back(r);
                end
            end else begin
                r.flags = 3'b010; r.data = 0;
                exp_resp.push_back(r);
            end
        end
        #1 check("stall_idle", {31'b0, stall}, {31'b0, !fl_idle && (rd || wr)});
        if (fl_idle || !(rd || wr)) begin
            @(negedge clk);
            ex_valid = 0; flush = 0;
        end else if (!legal) begin
            @(negedge clk);
            ex_valid = 0; Dmem_rd_en = 0; Dmem_wr_en = 0;
            #1 check("stall_err", {31'b0, stall}, 32'd0);
        end else begin
            for (int k = 1; ; k++) begin
                @(negedge clk);
                ex_valid = 0; Dmem_rd_en = 0; Dmem_wr_en = 0;
                flush = (k == f);
                mem_ack = (k == d);
                mem_rdata = (k == d) ? rw : $urandom;
                #1 check("stall_busy", {31'b0, stall}, 32'd1);
                if (k == d || (d == 0 && k == TIMEOUT)) break;
            end
            @(negedge clk);
            mem_ack = 0; flush = 0;
            #1;
            check("stall_end", {31'b0, stall}, 32'd0);
            check("mem_req_end", {31'b0, mem_req}, 32'd0);
        end
    endtask

    // Reset asserted in the second BUSY cycle of a load; the bus request must vanish
    task automatic reset_mid_busy();
        bus_t b;
        @(negedge clk);
        ex_valid = 1; flush = 0; Dmem_rd_en = 1; Dmem_wr_en = 0; MemRead = 0; addr = 32'h40; mem_ack = 0;
        b.addr = 32'h40; b.be = 4'hF; b.we = 0; b.wd = wdata;
        exp_bus.push_back(b);
        @(negedge clk);
        ex_valid = 0; Dmem_rd_en = 0;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, d, f;
        bit rd, wr;
        rst_n = 0; ex_valid = 0; flush = 0; Dmem_rd_en = 0; Dmem_wr_en = 0;
        MemWrite = 0; MemRead = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_be", {28'b0, mem_be}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_errs", {29'b0, rdata_valid, access_err, bus_err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1;
        run_txn(1, 0, 3'b001, 2'b00, 32'h103, 32'h0, 32'h80FF_1234, 3, 0, 0);
        run_txn(0, 1, 3'b000, 2'b10, 32'h202, 32'h0000_ABCD, 32'h1234_5678, 2, 0, 0);
        run_txn(1, 0, 3'b000, 2'b00, 32'h101, 32'h0, 32'h0, 1, 0, 0);
        run_txn(1, 0, 3'b100, 2'b00, 32'h000, 32'h0, 32'h0, 0, 0, 0);
        run_txn(1, 0, 3'b000, 2'b00, 32'h300, 32'h0, 32'hDEAD_BEEF, 5, 2, 0);
        run_txn(1, 0, 3'b010, 2'b00, 32'h102, 32'h0, 32'h8001_7FFF, 16, 0, 0);
        run_txn(1, 1, 3'b000, 2'b11, 32'h100, 32'h0, 32'h0, 1, 0, 0);
        run_txn(1, 0, 3'b101, 2'b00, 32'h100, 32'h0, 32'h0, 1, 0, 0);
        run_txn(0, 1, 3'b000, 2'b01, 32'h7, 32'h0000_00A5, 32'h0, 1, 0, 0);
        run_txn(1, 0, 3'b000, 2'b00, 32'h20, 32'h0, 32'h1111_2222, 1, 0, 1);
        reset_mid_busy();
        run_txn(1, 0, 3'b000, 2'b00, 32'h44, 32'h0, 32'hCAFE_F00D, 2, 0, 0);
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 19);
            rd = (r < 10) || (r == 19);
            wr = (r >= 10);
            r = $urandom_range(0, 9);
            d = (r == 0) ? 0 : (r == 1) ? 16 : (r == 2) ? 15 : $urandom_range(1, 4);
            f = ($urandom_range(0, 3) == 0 && d != 0) ? $urandom_range(1, d) : 0;
            run_txn(rd, wr, 3'($urandom_range(0, 7)), 2'($urandom_range(1, 3)),
                    $urandom & 32'h0000_FFFF, $urandom, $urandom, d, f, $urandom_range(0, 19) == 0);
        end
        repeat (3) @(negedge clk);
        check("bus_queue_empty", exp_bus.size(), 32'd0);
        check("resp_queue_empty", exp_resp.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
